// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: MV packing widths, lane counts,
// FSM state encoding and MV helpers for the best-MV selector.
package me_pkg;

   localparam int unsigned MVX_W = 5;
   localparam int unsigned MVY_W = 7;
   localparam int unsigned MV_W  = MVX_W + MVY_W;
   localparam int unsigned N8    = 16;
   localparam int unsigned N16   = 4;
   localparam int unsigned MAG_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Packs signed mvx/mvy into the {mvy, mvx} lane format.
   function automatic logic [MV_W-1:0] mv_pack(input logic [MVX_W-1:0] mvx,
                                               input logic [MVY_W-1:0] mvy);
      return {mvy, mvx};
   endfunction

   // |mvx| + |mvy| of a packed MV; the most negative values map to 16 and 64.
   function automatic logic [MAG_W-1:0] mv_mag(input logic [MV_W-1:0] mv);
      logic [MVX_W-1:0] x;
      logic [MVY_W-1:0] y;
      logic [MVX_W-1:0] ax;
      logic [MVY_W-1:0] ay;
      x  = mv[MVX_W-1:0];
      y  = mv[MV_W-1:MVX_W];
      ax = x[MVX_W-1] ? MVX_W'(-x) : x;
      ay = y[MVY_W-1] ? MVY_W'(-y) : y;
      return MAG_W'(ax) + MAG_W'(ay);
   endfunction

endpackage

// File: rtl/sad_min_lane.sv
// One partition lane: holds the running minimum SAD and its MV.
//   clear_i    : reload SAD to all-ones and MV to 0 (has priority)
//   upd_en_i   : current candidate is valid for comparison
//   sad_i/mv_i : candidate SAD and packed MV
//   best_sad_o / best_mv_o : stored minimum (registered)
// Optional macro SAD_SEL_ZERO_BIAS_EN: on equal SAD prefer the smaller |mvx|+|mvy|.
module sad_min_lane
   import me_pkg::*;
#(
   parameter int unsigned SAD_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             upd_en_i,
   input  logic [SAD_W-1:0] sad_i,
   input  logic [MV_W-1:0]  mv_i,
   output logic [SAD_W-1:0] best_sad_o,
   output logic [MV_W-1:0]  best_mv_o
);

   logic [SAD_W-1:0] sad_q, sad_d;
   logic [MV_W-1:0]  mv_q,  mv_d;
   logic             take_c;

   // Candidate acceptance: strict less, optionally broken ties toward zero MV.
   always_comb begin
      take_c = (sad_i < sad_q);
`ifdef SAD_SEL_ZERO_BIAS_EN
      if ((sad_i == sad_q) && (mv_mag(mv_i) < mv_mag(mv_q))) begin
         take_c = 1'b1;
      end
`endif
   end

   always_comb begin
      sad_d = sad_q;
      mv_d  = mv_q;
      if (clear_i) begin
         sad_d = '1;
         mv_d  = '0;
      end else if (upd_en_i && take_c) begin
         sad_d = sad_i;
         mv_d  = mv_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sad_q <= '1;
         mv_q  <= '0;
      end else begin
         sad_q <= sad_d;
         mv_q  <= mv_d;
      end
   end

   assign best_sad_o = sad_q;
   assign best_mv_o  = mv_q;

endmodule

// File: rtl/sad_best_mv_select.sv
// Best motion-vector selector: tracks per-partition minimum SAD and MV
// (16 x 8x8, 4 x 16x16, 1 x 32x32) over one search window.
//   start               : clear minima and (re)enter SEARCH
//   sad_valid/sad_last  : candidate strobe / final candidate marker
//   SAD8x8/16x16/32x32  : candidate SAD lanes
//   search_column_count / search_row_count : candidate position
//   busy / done         : in SEARCH / one-cycle results-final pulse
//   best_sad* / best_mv*: per-lane minima, MV lane = {mvy[6:0], mvx[4:0]}
// Optional macro SAD_SEL_ZERO_BIAS_EN: zero-MV bias on SAD ties.
module sad_best_mv_select
   import me_pkg::*;
#(
   parameter int unsigned MV_X_OFFSET = 16,
   parameter int unsigned MV_Y_OFFSET = 64,
   parameter int unsigned SAD8_W      = 14,
   parameter int unsigned SAD16_W     = 16,
   parameter int unsigned SAD32_W     = 18
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sad_valid,
   input  logic                  sad_last,
   input  logic [N8*SAD8_W-1:0]  SAD8x8,
   input  logic [N16*SAD16_W-1:0] SAD16x16,
   input  logic [SAD32_W-1:0]    SAD32x32,
   input  logic [MVX_W-1:0]      search_column_count,
   input  logic [MVY_W-1:0]      search_row_count,
   output logic                  busy,
   output logic                  done,
   output logic [N8*SAD8_W-1:0]  best_sad8x8,
   output logic [N8*MV_W-1:0]    best_mv8x8,
   output logic [N16*SAD16_W-1:0] best_sad16x16,
   output logic [N16*MV_W-1:0]   best_mv16x16,
   output logic [SAD32_W-1:0]    best_sad32x32,
   output logic [MV_W-1:0]       best_mv32x32
);

   state_e          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            upd_en_c;
   logic [MV_W-1:0] cand_mv_c;

   // State and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; start restarts from any state.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_SEARCH;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_SEARCH: if (sad_valid && sad_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs: status flags are registered from the next state so they
   // line up with the state register; start suppresses a same-cycle candidate.
   always_comb begin
      busy_d   = (state_d == ST_SEARCH);
      done_d   = (state_d == ST_DONE);
      upd_en_c = sad_valid && (state_q == ST_SEARCH) && !start;
   end

   // Candidate MV: offsets wrap in the lane width (two's complement).
   always_comb begin
      cand_mv_c = mv_pack(MVX_W'(search_column_count - MVX_W'(MV_X_OFFSET)),
                          MVY_W'(search_row_count    - MVY_W'(MV_Y_OFFSET)));
   end

   for (genvar i = 0; i < N8; i++) begin : g_l8
      sad_min_lane #(.SAD_W(SAD8_W)) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear_i    (start),
         .upd_en_i   (upd_en_c),
         .sad_i      (SAD8x8[i*SAD8_W +: SAD8_W]),
         .mv_i       (cand_mv_c),
         .best_sad_o (best_sad8x8[i*SAD8_W +: SAD8_W]),
         .best_mv_o  (best_mv8x8[i*MV_W +: MV_W])
      );
   end

   for (genvar i = 0; i < N16; i++) begin : g_l16
      sad_min_lane #(.SAD_W(SAD16_W)) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear_i    (start),
         .upd_en_i   (upd_en_c),
         .sad_i      (SAD16x16[i*SAD16_W +: SAD16_W]),
         .mv_i       (cand_mv_c),
         .best_sad_o (best_sad16x16[i*SAD16_W +: SAD16_W]),
         .best_mv_o  (best_mv16x16[i*MV_W +: MV_W])
      );
   end

   sad_min_lane #(.SAD_W(SAD32_W)) u_l32 (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (start),
      .upd_en_i   (upd_en_c),
      .sad_i      (SAD32x32),
      .mv_i       (cand_mv_c),
      .best_sad_o (best_sad32x32),
      .best_mv_o  (best_mv32x32)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_sad_best_mv_select.sv
// Directed self-checking bench for sad_best_mv_select.
module tb_sad_best_mv_select;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, sad_valid, sad_last;
   logic [223:0] SAD8x8;
   logic [63:0]  SAD16x16;
   logic [17:0]  SAD32x32;
   logic [4:0]   search_column_count;
   logic [6:0]   search_row_count;
   logic         busy, done;
   logic [223:0] best_sad8x8;
   logic [191:0] best_mv8x8;
   logic [63:0]  best_sad16x16;
   logic [47:0]  best_mv16x16;
   logic [17:0]  best_sad32x32;
   logic [11:0]  best_mv32x32;

   logic [13:0]  s8  [16];
   logic [15:0]  s16 [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 16; i++) SAD8x8[i*14 +: 14] = s8[i];
      for (int i = 0; i < 4; i++)  SAD16x16[i*16 +: 16] = s16[i];
   end

   sad_best_mv_select dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sad_valid(sad_valid),
      .sad_last(sad_last), .SAD8x8(SAD8x8), .SAD16x16(SAD16x16),
      .SAD32x32(SAD32x32), .search_column_count(search_column_count),
      .search_row_count(search_row_count), .busy(busy), .done(done),
      .best_sad8x8(best_sad8x8), .best_mv8x8(best_mv8x8),
      .best_sad16x16(best_sad16x16), .best_mv16x16(best_mv16x16),
      .best_sad32x32(best_sad32x32), .best_mv32x32(best_mv32x32)
   );

   // Advance one edge; inputs set before, outputs checked #1 after.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; sad_valid = 0; sad_last = 0;
      SAD32x32 = '1; search_column_count = 0; search_row_count = 0;
      for (int i = 0; i < 16; i++) s8[i] = '1;
      for (int i = 0; i < 4; i++)  s16[i] = '1;
   endtask

   task automatic cand(input logic [17:0] s, input logic [4:0] col,
                       input logic [6:0] row, input logic last);
      sad_valid = 1; sad_last = last; SAD32x32 = s;
      search_column_count = col; search_row_count = row;
      step();
      sad_valid = 0; sad_last = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
      n_cmp++; if (best_sad32x32 !== 18'h3FFFF) begin n_err++; $display("FAIL reset_sad32 got %h exp 3ffff", best_sad32x32); end
      n_cmp++; if (best_sad8x8 !== {224{1'b1}}) begin n_err++; $display("FAIL reset_sad8 got %h", best_sad8x8); end
      n_cmp++; if (best_mv8x8 !== 192'd0) begin n_err++; $display("FAIL reset_mv8 got %h exp 0", best_mv8x8); end
      rst_n = 1;
      step();
   endtask

   task automatic test_basic();
      start = 1; step(); start = 0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
      cand(18'd500, 5'd16, 7'd64, 0);
      n_cmp++; if (best_sad32x32 !== 18'd500 || best_mv32x32 !== 12'h000) begin n_err++; $display("FAIL basic_c0 got %0d/%h exp 500/000", best_sad32x32, best_mv32x32); end
      cand(18'd300, 5'd20, 7'd64, 0);
      n_cmp++; if (best_sad32x32 !== 18'd300 || best_mv32x32 !== 12'h004) begin n_err++; $display("FAIL basic_c1 got %0d/%h exp 300/004", best_sad32x32, best_mv32x32); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done got %b exp 0", done); end
      cand(18'd300, 5'd21, 7'd64, 1);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", done, busy); end
      n_cmp++; if (best_sad32x32 !== 18'd300 || best_mv32x32 !== 12'h004) begin n_err++; $display("FAIL basic_tie got %0d/%h exp 300/004", best_sad32x32, best_mv32x32); end
      n_cmp++; if (best_sad16x16 !== {64{1'b1}} || best_mv16x16 !== 48'd0) begin n_err++; $display("FAIL basic_16_allones got %h/%h", best_sad16x16, best_mv16x16); end
      step();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_post got done=%b busy=%b exp 0/0", done, busy); end
      n_cmp++; if (best_sad32x32 !== 18'd300) begin n_err++; $display("FAIL basic_hold got %0d exp 300", best_sad32x32); end
   endtask

   task automatic test_tie_bias();
      logic [11:0] exp_mv;
`ifdef SAD_SEL_ZERO_BIAS_EN
      exp_mv = 12'h001;
`else
      exp_mv = 12'h004;
`endif
      start = 1; step(); start = 0;
      cand(18'd100, 5'd20, 7'd64, 0);
      cand(18'd100, 5'd17, 7'd64, 1);
      n_cmp++; if (best_sad32x32 !== 18'd100 || best_mv32x32 !== exp_mv) begin n_err++; $display("FAIL tie_bias got %0d/%h exp 100/%h", best_sad32x32, best_mv32x32, exp_mv); end
      step();
   endtask

   task automatic test_lane_indep();
      logic [13:0] l0  [6];
      logic [13:0] l15 [6];
      logic [4:0]  cols [6];
      logic [6:0]  rows [6];
      l0   = '{14'd100, 14'd90, 14'd10, 14'd50, 14'd50, 14'd50};
      l15  = '{14'd100, 14'd90, 14'd80, 14'd70, 14'd60, 14'd5};
      cols = '{5'd0, 5'd1, 5'd3, 5'd5, 5'd7, 5'd9};
      rows = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd70};
      start = 1; step(); start = 0;
      for (int i = 0; i < 16; i++) s8[i] = 14'd200;
      for (int i = 0; i < 4; i++)  s16[i] = 16'(1000 + i);
      for (int c = 0; c < 6; c++) begin
         s8[0] = l0[c]; s8[15] = l15[c];
         cand('1, cols[c], rows[c], (c == 5));
      end
      n_cmp++; if (best_sad8x8[0 +: 14] !== 14'd10 || best_mv8x8[0 +: 12] !== 12'h813) begin n_err++; $display("FAIL lane0 got %0d/%h exp 10/813", best_sad8x8[0 +: 14], best_mv8x8[0 +: 12]); end
      n_cmp++; if (best_sad8x8[210 +: 14] !== 14'd5 || best_mv8x8[180 +: 12] !== 12'h0D9) begin n_err++; $display("FAIL lane15 got %0d/%h exp 5/0d9", best_sad8x8[210 +: 14], best_mv8x8[180 +: 12]); end
      n_cmp++; if (best_sad8x8[98 +: 14] !== 14'd200 || best_mv8x8[84 +: 12] !== 12'h810) begin n_err++; $display("FAIL lane7 got %0d/%h exp 200/810", best_sad8x8[98 +: 14], best_mv8x8[84 +: 12]); end
      n_cmp++; if (best_sad16x16[48 +: 16] !== 16'd1003 || best_mv16x16[36 +: 12] !== 12'h810) begin n_err++; $display("FAIL lane16_3 got %0d/%h exp 1003/810", best_sad16x16[48 +: 16], best_mv16x16[36 +: 12]); end
      n_cmp++; if (best_sad32x32 !== 18'h3FFFF || best_mv32x32 !== 12'h000) begin n_err++; $display("FAIL lane32_max got %h/%h exp 3ffff/000", best_sad32x32, best_mv32x32); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL lane_done got %b exp 1", done); end
      idle_inputs();
      step();
   endtask

   task automatic test_idle_and_start_priority();
      sad_valid = 1; SAD32x32 = 18'd7; search_column_count = 5'd16; search_row_count = 7'd64;
      step(); step();
      sad_valid = 0;
      n_cmp++; if (busy !== 1'b0 || best_sad32x32 !== 18'h3FFFF) begin n_err++; $display("FAIL idle_valid got busy=%b sad=%h exp 0/3ffff", busy, best_sad32x32); end
      start = 1; sad_valid = 1; SAD32x32 = 18'd1;
      step();
      start = 0; sad_valid = 0;
      n_cmp++; if (busy !== 1'b1 || best_sad32x32 !== 18'h3FFFF) begin n_err++; $display("FAIL start_prio got busy=%b sad=%h exp 1/3ffff", busy, best_sad32x32); end
      sad_last = 1; step(); sad_last = 0;
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL last_no_valid got busy=%b done=%b exp 1/0", busy, done); end
      cand(18'd50, 5'd18, 7'd64, 1);
      n_cmp++; if (best_sad32x32 !== 18'd50 || best_mv32x32 !== 12'h002 || done !== 1'b1) begin n_err++; $display("FAIL after_prio got %0d/%h done=%b exp 50/002/1", best_sad32x32, best_mv32x32, done); end
      step();
   endtask

   task automatic test_reset_mid();
      int done_seen = 0;
      start = 1; step(); start = 0;
      cand(18'd400, 5'd16, 7'd64, 0);
      sad_valid = 1; SAD32x32 = 18'd200; search_column_count = 5'd17;
      #2 rst_n = 0;
      #1;
      n_cmp++; if (busy !== 1'b0 || best_sad32x32 !== 18'h3FFFF || best_mv32x32 !== 12'h000) begin n_err++; $display("FAIL mid_reset got busy=%b %h/%h exp 0/3ffff/000", busy, best_sad32x32, best_mv32x32); end
      step();
      rst_n = 1;
      cand(18'd150, 5'd18, 7'd64, 0);
      if (done) done_seen++;
      cand(18'd120, 5'd19, 7'd64, 1);
      if (done) done_seen++;
      step();
      if (done) done_seen++;
      n_cmp++; if (done_seen !== 0 || best_sad32x32 !== 18'h3FFFF) begin n_err++; $display("FAIL post_reset_idle got done_seen=%0d sad=%h exp 0/3ffff", done_seen, best_sad32x32); end
      start = 1; step(); start = 0;
      cand(18'd77, 5'd16, 7'd64, 1);
      n_cmp++; if (best_sad32x32 !== 18'd77 || done !== 1'b1) begin n_err++; $display("FAIL clean_search got %0d done=%b exp 77/1", best_sad32x32, done); end
      step();
   endtask

   task automatic test_restart();
      start = 1; step(); start = 0;
      cand(18'd20, 5'd16, 7'd64, 0);
      n_cmp++; if (best_sad32x32 !== 18'd20) begin n_err++; $display("FAIL restart_pre got %0d exp 20", best_sad32x32); end
      start = 1; step(); start = 0;
      n_cmp++; if (best_sad32x32 !== 18'h3FFFF || busy !== 1'b1) begin n_err++; $display("FAIL restart_clear got %h busy=%b exp 3ffff/1", best_sad32x32, busy); end
      cand(18'd60, 5'd17, 7'd64, 1);
      n_cmp++; if (best_sad32x32 !== 18'd60 || best_mv32x32 !== 12'h001 || done !== 1'b1) begin n_err++; $display("FAIL restart_res got %0d/%h done=%b exp 60/001/1", best_sad32x32, best_mv32x32, done); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie_bias();
      test_lane_indep();
      test_idle_and_start_priority();
      test_reset_mid();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sad_best_mv_select.md
Name: sad_best_mv_select

Overview:
- Consumes the per-candidate SAD vectors produced by the basic-layer search pipeline.
- Tracks the minimum SAD and its motion vector for each partition: 16 x 8x8, 4 x 16x16 and 1 x 32x32.
- After the last candidate it presents the 21 best (SAD, MV) pairs to the next search layer or to mode decision.
- Sits directly downstream of the SAD tree output and the search column/row counters.

Parameters:
- MV_X_OFFSET, 16: subtracted from search_column_count to form signed mvx.
- MV_Y_OFFSET, 64: subtracted from search_row_count to form signed mvy.
- SAD8_W, 14: width of one 8x8 SAD lane.
- SAD16_W, 16: width of one 16x16 SAD lane.
- SAD32_W, 18: width of the 32x32 SAD.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; clears all minima and enters SEARCH.
- sad_valid  in  1  the current SAD inputs and counts are one candidate.
- sad_last  in  1  qualifies sad_valid; marks the final candidate of the search window.
- SAD8x8  in  224  16 lanes x SAD8_W; lane i at bits [14i+13:14i].
- SAD16x16  in  64  4 lanes x SAD16_W.
- SAD32x32  in  18  single SAD.
- search_column_count  in  5  candidate column position.
- search_row_count  in  7  candidate row position.
- busy  out  1  high in SEARCH.
- done  out  1  one-cycle pulse when results are final.
- best_sad8x8  out  224  per-lane minimum SAD.
- best_mv8x8  out  192  16 x {mvy[6:0], mvx[4:0]}, lane i at [12i+11:12i].
- best_sad16x16  out  64  per-lane minimum SAD.
- best_mv16x16  out  48  4 x 12-bit MV.
- best_sad32x32  out  18  minimum SAD.
- best_mv32x32  out  12  MV.

Behaviour:
- State machine IDLE, SEARCH, DONE.
  - Reset value: IDLE.
  - IDLE -> SEARCH on start.
  - SEARCH -> DONE on sad_valid & sad_last.
  - DONE -> IDLE unconditionally after one cycle.
  - start in any state -> SEARCH (restart).
- Reset values: all outputs 0, except best_sad* lanes, which reset to all-ones (maximum value).
- start clears every best_sad lane to all-ones and every best_mv to 0.
  - sad_valid in the same cycle as start is discarded; start has priority.
- In SEARCH, each sad_valid cycle compares every lane independently.
  - A lane updates when input SAD < stored SAD (strict).
  - On update, the lane stores the SAD and the MV.
  - MV: mvx = search_column_count - MV_X_OFFSET, 5-bit two's complement, wrap allowed. mvy = search_row_count - MV_Y_OFFSET, 7-bit two's complement.
  - Registers update at the edge that samples sad_valid. Results are visible the next cycle.
- Candidate 0 always wins against the cleared all-ones value, unless its SAD is itself all-ones. In that case the lane keeps MV 0.
- Ties: the earlier candidate is retained (default build).
- sad_valid outside SEARCH (IDLE or DONE) is ignored. sad_last without sad_valid is ignored.
- busy is registered and equals (state == SEARCH).
- done is high for exactly the one cycle in DONE, i.e. the cycle after the last candidate was sampled.
- best_* outputs hold stable from DONE until the next start or reset.
- Asynchronous reset mid-search returns to IDLE immediately with the reset values above. No partial results survive.
- No back-pressure: one candidate per cycle is accepted in SEARCH.

Optional Feature:
- Macro SAD_SEL_ZERO_BIAS_EN.
- Defined: on an equal SAD, the lane updates if |mvx|+|mvy| of the new candidate is strictly less than that of the stored MV. This adds one small magnitude compare per lane.
- Undefined: strict-less compare only, as above.

Decomposition:
- Shared package (me_pkg) holds:
  - MV packing widths: MVX_W=5, MVY_W=7, MV_W=12.
  - Lane counts: N8=16, N16=4.
  - State enum.
  - MV pack function.
- One natural sub-module, sad_min_lane. It is parameterized by SAD width and holds one SAD register, one MV register and the compare (including the optional bias). It is instantiated 21 times by generate loops.
- The top holds the FSM and lane slicing.

Test Plan:
- Reset, then start, then 3 candidates with SAD32x32 = 500, 300, 300 at columns 16, 20, 21 and row 64; the third has sad_last=1 -> done pulses 1 cycle after the third; best_sad32x32=300, best_mv32x32 mvx=+4, mvy=0 (tie keeps the earlier candidate); busy low after DONE.
- Rebuild with SAD_SEL_ZERO_BIAS_EN, candidates SAD=100 at (col 20,row 64) then SAD=100 at (col 17,row 64) -> MV updates to mvx=+1.
- 8x8 lane independence: lane 0 minimum at candidate 2 (col 3, row 0) and lane 15 minimum at candidate 5 -> each lane reports its own MV; lane 0 mvx = 3-16 = -13 (5'b10011), mvy = -64.
- sad_valid pulses in IDLE, then start asserted together with sad_valid carrying SAD 1 -> that candidate is discarded; after one more candidate of SAD 50, best=50.
- Assert rst_n low during the 2nd of 4 candidates -> state IDLE, best_sad all-ones, done never pulses; start afterwards runs a clean search.
- start asserted mid-SEARCH -> minima cleared; results reflect only post-restart candidates.
